fifo_burst_reader: RTL and testbench

Consumer-side engine for the team's synchronous FIFO (registered read data, one-cycle read latency, `empty` flag). On a length command it pops exactly that many words from the FIFO and presents them on a valid/ready output stream with a `last` marker, absorbing the FIFO's read latency and downstream backpressure in a 2-entry output buffer. It sits between a FIFO instance and any streaming sink (packetiser, DMA write side).

---
 rtl/fifo_burst_reader_if.sv | 37 +++
 rtl/fifo_burst_reader.sv | 128 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - command, FIFO read-port and output-stream bundle for fifo_burst_reader
//
// Signals:
//   cmd_valid/cmd_len/cmd_ready      burst command handshake
//   fifo_rd_en/fifo_empty/fifo_rd_data  FIFO read port (registered data, 1-cycle latency)
//   out_valid/out_data/out_last/out_ready  output stream
//   done                             one-cycle pulse after the final beat of a burst
// Modports:
//   master  the burst reader
//   slave   the surrounding system (command source, FIFO, sink)

interface fifo_burst_reader_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_ready;
    logic              fifo_rd_en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              done;

    modport master (
        input  cmd_valid, cmd_len, fifo_empty, fifo_rd_data, out_ready,
        output cmd_ready, fifo_rd_en, out_valid, out_data, out_last, done
    );

    modport slave (
        output cmd_valid, cmd_len, fifo_empty, fifo_rd_data, out_ready,
        input  cmd_ready, fifo_rd_en, out_valid, out_data, out_last, done
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops a commanded number of words from a FIFO onto a valid/ready stream
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   fifo_burst_reader_if.master: command in, FIFO read port, output stream, done pulse
//
// A 2-entry output buffer absorbs the FIFO's one-cycle read latency and sink
// backpressure. Pops are only issued when the words already held plus the word
// in flight, less the one leaving this cycle, leave room for another.

module fifo_burst_reader #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_burst_reader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  issue_left;
    logic [LEN_W-1:0]  beat_left;
    logic [1:0]        count;
    logic              inflight;
    logic [DATA_W-1:0] buf_mem [2];
    logic              head;
    logic              tail;

    logic              have_word;
    logic              pop_out;
    logic              rd_en;
    logic              accept;
    logic [2:0]        occ;

    // Outputs are forced to their reset values while rst is held so that no
    // pop or beat can slip out in the cycle that is being reset.
    always_comb begin
        state_nxt = state;
        have_word = (count != 2'd0) && !rst;
        pop_out   = have_word && bus.out_ready;
        accept    = (state == IDLE) && bus.cmd_valid && !rst;
        // Occupancy after this cycle if a pop were not issued: buffered + in flight - leaving.
        occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop_out};
        rd_en     = (state == RUN) && (issue_left != '0) && !bus.fifo_empty
                    && (occ < 3'd2) && !rst;

        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = (bus.cmd_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (pop_out && (beat_left == LEN_ONE)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready  = (state == IDLE) && !rst;
    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = have_word;
    assign bus.out_data   = rst ? '0 : buf_mem[head];
    assign bus.out_last   = have_word && (beat_left == LEN_ONE);
    assign bus.done       = (state == FIN) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issue_left <= '0;
            beat_left  <= '0;
            count      <= 2'd0;
            inflight   <= 1'b0;
            head       <= 1'b0;
            tail       <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;

            if (accept) begin
                issue_left <= bus.cmd_len;
                beat_left  <= bus.cmd_len;
            end else begin
                if (rd_en) begin
                    issue_left <= issue_left - LEN_ONE;
                end
                if (pop_out) begin
                    beat_left <= beat_left - LEN_ONE;
                end
            end

            // FIFO data registered on the previous pop lands in the tail now.
            if (inflight) begin
                buf_mem[tail] <= bus.fifo_rd_data;
                tail          <= ~tail;
            end
            if (pop_out) begin
                head <= ~head;
            end

            unique case ({inflight, pop_out})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader

module tb_fifo_burst_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATA_W(32), .LEN_W(8)) bus ();

    fifo_burst_reader #(.DATA_W(32), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model: registered read data, 1-cycle latency ----------------
    logic        push_valid;
    logic [31:0] push_data;
    logic [31:0] fmem [0:1023];
    int          wp = 0;
    int          rp = 0;

    assign bus.fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (push_valid) begin
            fmem[wp] <= push_data;
            wp       <= wp + 1;
        end
        if (bus.fifo_rd_en && (rp != wp)) begin
            bus.fifo_rd_data <= fmem[rp];
            rp               <= rp + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] pushed [$];
    logic [31:0] pend   [$];
    logic [31:0] got    [$];
    int          push_period = 1;
    bit          rand_ready  = 1'b0;
    int          cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        push_valid = 1'b0;
        if (pend.size() > 0 &&
            (push_period == 1 ||
             (push_period == 4 && (cyc % 4) == 0) ||
             (push_period == 0 && $urandom_range(0, 2) != 0))) begin
            push_valid = 1'b1;
            push_data  = pend.pop_front();
            pushed.push_back(push_data);
        end
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic run_burst(input int len, input int max_cyc, output int lasts, output int dones);
        int n;
        n = 0;
        lasts = 0;
        dones = 0;
        got.delete();
        tick();
        while (!bus.cmd_ready && n < 100) begin
            tick();
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'(len);
        n = 0;
        do begin
            tick();
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                if (bus.out_last) lasts++;
            end
            if (bus.done) dones++;
            n++;
        end while (!bus.done && n < max_cyc);
        if (!bus.done) chk("burst_timeout", 64'(n), 64'(max_cyc + 1));
    endtask

    // ---------------- behavioural reference, checked every cycle ----------------
    // Output k of a burst must be the k-th word after the words already popped when
    // the burst started; occupancy is words captured (pops two or more cycles ago)
    // minus beats already taken.
    bit busy     = 1'b0;
    bit done_now = 1'b0;
    int cur_len  = 0;
    int base     = 0;
    int total_pops = 0;
    int b_pops = 0;
    int b_cap  = 0;
    int b_hs   = 0;
    bit pop_d1 = 1'b0;

    always @(negedge clk) begin
        int occ;
        int idx;
        if (rst) begin
            chk("rst_cmd_ready",  bus.cmd_ready,  0);
            chk("rst_fifo_rd_en", bus.fifo_rd_en, 0);
            chk("rst_out_valid",  bus.out_valid,  0);
            chk("rst_out_last",   bus.out_last,   0);
            chk("rst_out_data",   bus.out_data,   0);
            chk("rst_done",       bus.done,       0);
            busy = 1'b0; done_now = 1'b0;
            b_pops = 0; b_cap = 0; b_hs = 0; pop_d1 = 1'b0;
            base = total_pops;
        end else begin
            occ = b_cap - b_hs;
            chk("cmd_ready", bus.cmd_ready, 64'(!busy));
            chk("done", bus.done, 64'(done_now));
            chk("occupancy_le_2", 64'(occ <= 2), 1);
            chk("out_valid", bus.out_valid, 64'(occ > 0));
            if (bus.out_valid) begin
                idx = base + b_hs;
                if (idx < pushed.size()) chk("out_data", bus.out_data, pushed[idx]);
                else chk("out_data_beyond_pushed", 64'(idx), 64'(pushed.size()));
                chk("out_last", bus.out_last, 64'(b_hs == cur_len - 1));
            end
            if (bus.fifo_rd_en) begin
                chk("rd_en_while_empty", bus.fifo_empty, 0);
                chk("rd_en_only_busy", 64'(busy), 1);
                chk("pops_le_len", 64'(b_pops < cur_len), 1);
            end
            if (done_now) begin
                chk("pops_at_done", 64'(b_pops), 64'(cur_len));
                busy = 1'b0;
                done_now = 1'b0;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                busy = 1'b1;
                cur_len = int'(bus.cmd_len);
                base = total_pops;
                b_pops = 0; b_cap = 0; b_hs = 0; pop_d1 = 1'b0;
                if (cur_len == 0) done_now = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (b_hs == cur_len - 1) done_now = 1'b1;
                b_hs++;
            end
            b_cap += int'(pop_d1);
            pop_d1 = bus.fifo_rd_en;
            if (bus.fifo_rd_en) begin
                b_pops++;
                total_pops++;
            end
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        int pops;
        int beats;
        int lasts;
        int dones;

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;
        push_valid    = 1'b0;
        push_data     = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("reset_cmd_ready_low", bus.cmd_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready_after", bus.cmd_ready, 1);
        chk("reset_out_valid_after", bus.out_valid, 0);
        chk("reset_done_after", bus.done, 0);

        // Basic burst: A0..A3, len 4, full throughput
        for (int i = 0; i < 4; i++) pend.push_back(32'hA0 + 32'(i));
        repeat (5) tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd4;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            chk("basic_rd_en", bus.fifo_rd_en, 64'(k >= 1 && k <= 4));
            chk("basic_out_valid", bus.out_valid, 64'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk("basic_out_data", bus.out_data, 64'(32'hA0 + 32'(k - 3)));
            chk("basic_out_last", bus.out_last, 64'(k == 6));
            chk("basic_done", bus.done, 64'(k == 7));
            chk("basic_cmd_ready", bus.cmd_ready, 64'(k == 8));
        end

        // Backpressure: len 6, FIFO full, sink stalled 10 cycles
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) pend.push_back(32'hB0 + 32'(i));
        repeat (7) tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd6;
        pops = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            if (bus.fifo_rd_en) pops++;
            if (k >= 3) begin
                chk("bp_held_valid", bus.out_valid, 1);
                chk("bp_held_data", bus.out_data, 32'hB0);
            end
        end
        chk("bp_pops_while_stalled", 64'(pops), 2);
        for (int k = 0; k < 6; k++) begin
            tick();
            bus.out_ready = 1'b1;
            @(negedge clk);
            chk("bp_beat_valid", bus.out_valid, 1);
            chk("bp_beat_data", bus.out_data, 64'(32'hB0 + 32'(k)));
            chk("bp_beat_last", bus.out_last, 64'(k == 5));
        end
        tick();
        @(negedge clk);
        chk("bp_done", bus.done, 1);

        // Empty stall: len 3, one word pushed every 4 cycles
        push_period = 4;
        for (int i = 0; i < 3; i++) pend.push_back(32'hC0 + 32'(i));
        run_burst(3, 200, lasts, dones);
        chk("empty_beats", 64'(got.size()), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("empty_data", got[i], 64'(32'hC0 + 32'(i)));
        chk("empty_lasts", 64'(lasts), 1);
        chk("empty_dones", 64'(dones), 1);

        // Zero length, with FIFO holding data that must not be touched
        push_period = 1;
        for (int i = 0; i < 10; i++) pend.push_back(32'hD0 + 32'(i));
        repeat (12) tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            chk("zero_done", bus.done, 64'(k == 1));
            chk("zero_cmd_ready", bus.cmd_ready, 64'(k == 2));
            chk("zero_rd_en", bus.fifo_rd_en, 0);
            chk("zero_out_valid", bus.out_valid, 0);
        end

        // Mid-burst reset after the third beat
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd8;
        beats = 0;
        for (int k = 0; k < 40 && beats < 3; k++) begin
            tick();
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) beats++;
        end
        chk("mid_three_beats", 64'(beats), 3);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_after_cmd_ready", bus.cmd_ready, 1);
            chk("mid_after_out_valid", bus.out_valid, 0);
            chk("mid_after_rd_en", bus.fifo_rd_en, 0);
            chk("mid_after_done", bus.done, 0);
            tick();
        end
        run_burst(2, 100, lasts, dones);
        chk("mid_new_beats", 64'(got.size()), 2);
        if (got.size() == 2) begin
            chk("mid_new_word0", got[0], 32'hD5);
            chk("mid_new_word1", got[1], 32'hD6);
        end
        chk("mid_new_lasts", 64'(lasts), 1);

        // Extremes: 255-word burst under random pacing, then a 1-word burst at once
        push_period = 0;
        rand_ready  = 1'b1;
        for (int i = 0; i < 256; i++) pend.push_back(32'h1000 + 32'(i));
        run_burst(255, 5000, lasts, dones);
        chk("ext255_beats", 64'(got.size()), 255);
        chk("ext255_lasts", 64'(lasts), 1);
        chk("ext255_dones", 64'(dones), 1);
        if (got.size() > 3) begin
            chk("ext255_first", got[0], 32'hD7);
            chk("ext255_fourth", got[3], 32'h1000);
        end
        run_burst(1, 500, lasts, dones);
        chk("ext1_beats", 64'(got.size()), 1);
        chk("ext1_lasts", 64'(lasts), 1);
        chk("ext1_dones", 64'(dones), 1);
        if (got.size() == 1) chk("ext1_word", got[0], 32'h10000 > 0 ? 32'h10FC : 32'h0);

        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
